x_cal_sweep: RTL and testbench
==============================

X_CAL_SWEEP -- requirements
Module: x_cal_sweep

Interface
REQ-001 SHALL have parameter p_width, default 256: capture vector width.
REQ-002 SHALL have parameter p_ctrl_w, default 8: tap index width; there are 2**p_ctrl_w taps.
REQ-003 SHALL have parameter p_settle, default 16: settle cycles after every tap change; minimum 1.
REQ-004 i_clk  in  1  sole clock.
REQ-005 i_nrst  in  1  reset, asynchronous, active-low.
REQ-006 i_start  in  1  one-cycle pulse; starts a run.
REQ-007 i_abort  in  1  level; forces return to IDLE.
REQ-008 i_mode  in  1  run mode: 0 = sweep, 1 = hold on a single tap.
REQ-009 i_first, i_last, i_step  in  p_ctrl_w each  sweep start tap, end tap and increment.
REQ-010 i_trig  in  1  asynchronous capture trigger; active on its falling edge.
REQ-011 i_data  in  p_width  delay-line snapshot.
REQ-012 o_ctrl  out  2**p_ctrl_w  one-hot variable-delay select.
REQ-013 o_tap  out  p_ctrl_w  current tap index.
REQ-014 o_valid / i_ready  out / in  1 each  result handshake.
REQ-015 o_data  out  p_width  captured vector.
REQ-016 o_ones  out  clog2(p_width+1)  population count of o_data.
REQ-017 o_busy, o_done, o_missed  out  1 each  run active; end-of-sweep pulse; sticky missed-trigger flag.

Function
REQ-018 SHALL pass i_trig through a 2-flop synchroniser (both flops reset to 1); trig_edge = stage1 low AND stage2 high.
REQ-019 SHALL implement FSM states IDLE, SETTLE, ARM, SEND.
REQ-020 SHALL drive o_ctrl = 1 << o_tap combinationally at all times.
REQ-021 IDLE: on i_start, SHALL latch i_mode, i_last and i_step (i_step = 0 treated as 1), load o_tap <= i_first, clear o_missed, and go to SETTLE.
REQ-022 SHALL ignore i_start in every state other than IDLE.
REQ-023 SETTLE: SHALL count p_settle cycles from tap load, then enter ARM; the first cycle in which trig_edge is honoured is the (p_settle+1)th cycle after entry.
REQ-024 ARM: on trig_edge, SHALL register i_data into o_data and its popcount into o_ones in the same edge, enter SEND, and assert o_valid on the next cycle.
REQ-025 SEND: o_valid, o_data, o_ones and o_tap SHALL stay stable until the cycle with o_valid && i_ready.
REQ-026 On handshake with hold mode, SHALL return to ARM with the same tap and no settle.
REQ-027 On handshake with sweep mode, SHALL compute nxt = o_tap + step in p_ctrl_w+1 bits.
REQ-028 If nxt > last or nxt >= 2**p_ctrl_w: SHALL go to IDLE, pulse o_done for 1 cycle, and keep o_tap unchanged.
REQ-029 Otherwise: SHALL set o_tap <= nxt and go to SETTLE.
REQ-030 i_first > i_last SHALL yield exactly one capture at i_first, then o_done.
REQ-031 trig_edge in IDLE or SETTLE SHALL be ignored.
REQ-032 trig_edge in SEND SHALL set o_missed, which stays set until the next accepted i_start.
REQ-033 i_abort SHALL take priority over all transitions: next state IDLE, o_valid = 0, no o_done, o_tap retained.
REQ-034 i_abort and i_start in the same IDLE cycle: abort wins, no run starts.
REQ-035 o_busy SHALL be 1 in every state except IDLE.

Reset
REQ-036 On i_nrst low, SHALL set state IDLE, o_tap 0 (o_ctrl = 1), o_data 0, o_ones 0, o_valid 0, o_busy 0, o_done 0, o_missed 0, settle counter 0, synchroniser flops 1.
REQ-037 Reset asserted mid-run SHALL abandon the run immediately, with no o_done pulse.

Verification
REQ-038 Sweep, p_ctrl_w = 8, first 0, last 3, step 1, trig each ARM, i_ready = 1 -> four results at taps 0..3, o_ctrl 0x1,0x2,0x4,0x8, then o_done once.
REQ-039 first 250, last 255, step 4 -> captures at 250 and 254; nxt = 258 ends the run; o_tap stays 254.
REQ-040 i_data = 0x0F (p_width 256) captured with i_ready held low 10 cycles, plus a trig edge during SEND -> o_data/o_ones(4) stable, o_missed = 1 after that edge, cleared by next i_start.
REQ-041 Hold mode, tap 7, three triggers -> three results all at tap 7 with no settle gap; trig edge 5 cycles after a tap change in sweep (p_settle 16) -> ignored.
REQ-042 i_abort in SEND -> o_valid drops next cycle, IDLE, no o_done; i_nrst pulse mid-SETTLE -> all outputs at reset values.
REQ-043 step 0, first 2, last 4 -> behaves as step 1: taps 2, 3, 4.

Source files
------------

// File: rtl/x_cal_sweep.sv
`default_nettype none
// ============================================================================
// Module      : x_cal_sweep
// Description : Delay-line calibration sweeper. Steps a one-hot variable-delay
//               select across a tap range (or holds one tap), waits a settle
//               time after every tap change, captures a delay-line snapshot on
//               the falling edge of an asynchronous trigger and hands the
//               vector plus its population count out over a valid/ready port.
// Revision    : 1.0  initial release
// ============================================================================
module x_cal_sweep #(
    parameter int p_width  = 256,
    parameter int p_ctrl_w = 8,
    parameter int p_settle = 16
) (
    input  logic                           i_clk,
    input  logic                           i_nrst,
    input  logic                           i_start,
    input  logic                           i_abort,
    input  logic                           i_mode,
    input  logic [p_ctrl_w-1:0]            i_first,
    input  logic [p_ctrl_w-1:0]            i_last,
    input  logic [p_ctrl_w-1:0]            i_step,
    input  logic                           i_trig,
    input  logic [p_width-1:0]             i_data,
    output logic [(2**p_ctrl_w)-1:0]       o_ctrl,
    output logic [p_ctrl_w-1:0]            o_tap,
    output logic                           o_valid,
    input  logic                           i_ready,
    output logic [p_width-1:0]             o_data,
    output logic [$clog2(p_width+1)-1:0]   o_ones,
    output logic                           o_busy,
    output logic                           o_done,
    output logic                           o_missed
);

    localparam int taps   = 2**p_ctrl_w;
    localparam int ones_w = $clog2(p_width+1);
    localparam int cnt_w  = (p_settle > 1) ? $clog2(p_settle) : 1;
    localparam logic [cnt_w-1:0] settle_last = cnt_w'(p_settle - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        ARM    = 2'd2,
        SEND   = 2'd3
    } state_t;

    state_t                state;
    state_t                next_state;

    logic                  trig_s1;
    logic                  trig_s2;
    logic                  trig_edge;

    logic [cnt_w-1:0]      settle_cnt;
    logic                  mode_q;
    logic [p_ctrl_w-1:0]   last_q;
    logic [p_ctrl_w-1:0]   step_q;
    logic [p_ctrl_w:0]     nxt_tap;
    logic                  sweep_end;

    logic                  do_start;
    logic                  do_capture;
    logic                  do_advance;
    logic                  do_done;
    logic                  set_missed;

    function automatic logic [ones_w-1:0] popcount(input logic [p_width-1:0] v);
        logic [ones_w-1:0] n;
        n = '0;
        for (int k = 0; k < p_width; k++) begin
            n = n + ones_w'(v[k]);
        end
        return n;
    endfunction

    // Falling edge of the trigger is seen as stage1 low while stage2 still high.
    assign trig_edge = ~trig_s1 & trig_s2;

    // The extra bit catches a wrap past the top tap as an end-of-sweep.
    assign nxt_tap   = {1'b0, o_tap} + {1'b0, step_q};
    assign sweep_end = (nxt_tap > {1'b0, last_q}) || nxt_tap[p_ctrl_w];

    assign o_ctrl  = {{(taps-1){1'b0}}, 1'b1} << o_tap;
    assign o_valid = (state == SEND);
    assign o_busy  = (state != IDLE);

    // Two-flop synchroniser for the asynchronous trigger, idling high.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            trig_s1 <= 1'b1;
            trig_s2 <= 1'b1;
        end else begin
            trig_s1 <= i_trig;
            trig_s2 <= trig_s1;
        end
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and per-cycle actions; abort overrides every transition.
    always_comb begin
        next_state = state;
        do_start   = 1'b0;
        do_capture = 1'b0;
        do_advance = 1'b0;
        do_done    = 1'b0;
        set_missed = 1'b0;
        if (i_abort) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (i_start) begin
                        next_state = SETTLE;
                        do_start   = 1'b1;
                    end
                end
                SETTLE: begin
                    if (settle_cnt == settle_last) begin
                        next_state = ARM;
                    end
                end
                ARM: begin
                    if (trig_edge) begin
                        next_state = SEND;
                        do_capture = 1'b1;
                    end
                end
                SEND: begin
                    if (trig_edge) begin
                        set_missed = 1'b1;
                    end
                    if (i_ready) begin
                        if (mode_q) begin
                            next_state = ARM;
                        end else if (sweep_end) begin
                            next_state = IDLE;
                            do_done    = 1'b1;
                        end else begin
                            next_state = SETTLE;
                            do_advance = 1'b1;
                        end
                    end
                end
                default: begin
                    next_state = IDLE;
                end
            endcase
        end
    end

    // Settle counter runs only while staying in SETTLE, so every entry starts at zero.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            settle_cnt <= '0;
        end else if (state == SETTLE && next_state == SETTLE) begin
            settle_cnt <= settle_cnt + 1'b1;
        end else begin
            settle_cnt <= '0;
        end
    end

    // Run configuration, tap index and status flags.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            mode_q   <= 1'b0;
            last_q   <= '0;
            step_q   <= '0;
            o_tap    <= '0;
            o_done   <= 1'b0;
            o_missed <= 1'b0;
        end else begin
            o_done <= do_done;
            if (do_start) begin
                mode_q   <= i_mode;
                last_q   <= i_last;
                step_q   <= (i_step == '0) ? p_ctrl_w'(1) : i_step;
                o_tap    <= i_first;
                o_missed <= 1'b0;
            end else begin
                if (do_advance) begin
                    o_tap <= nxt_tap[p_ctrl_w-1:0];
                end
                if (set_missed) begin
                    o_missed <= 1'b1;
                end
            end
        end
    end

    // Capture register: snapshot and its popcount land on the same edge.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            o_data <= '0;
            o_ones <= '0;
        end else if (do_capture) begin
            o_data <= i_data;
            o_ones <= popcount(i_data);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_x_cal_sweep.sv
`default_nettype none
// ============================================================================
// Module      : tb_x_cal_sweep
// Description : Scoreboard bench for x_cal_sweep: stimulus pushes expected
//               results, a negedge monitor pops and compares on handshake.
// Revision    : 1.0  initial release
// ============================================================================
module tb_x_cal_sweep;

    logic         i_clk = 1'b0;
    logic         i_nrst;
    logic         i_start;
    logic         i_abort;
    logic         i_mode;
    logic [7:0]   i_first;
    logic [7:0]   i_last;
    logic [7:0]   i_step;
    logic         i_trig;
    logic [255:0] i_data;
    logic [255:0] o_ctrl;
    logic [7:0]   o_tap;
    logic         o_valid;
    logic         i_ready;
    logic [255:0] o_data;
    logic [8:0]   o_ones;
    logic         o_busy;
    logic         o_done;
    logic         o_missed;

    typedef struct {
        logic [7:0]   tap;
        logic [255:0] ctrl;
        logic [255:0] data;
        logic [8:0]   ones;
    } exp_t;

    exp_t q[$];
    int   checks    = 0;
    int   errors    = 0;
    int   pops      = 0;
    int   done_seen = 0;

    x_cal_sweep #(.p_width(256), .p_ctrl_w(8), .p_settle(16)) dut (
        .i_clk    (i_clk),
        .i_nrst   (i_nrst),
        .i_start  (i_start),
        .i_abort  (i_abort),
        .i_mode   (i_mode),
        .i_first  (i_first),
        .i_last   (i_last),
        .i_step   (i_step),
        .i_trig   (i_trig),
        .i_data   (i_data),
        .o_ctrl   (o_ctrl),
        .o_tap    (o_tap),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_data   (o_data),
        .o_ones   (o_ones),
        .o_busy   (o_busy),
        .o_done   (o_done),
        .o_missed (o_missed)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: compare every accepted result against the oldest expectation.
    always @(negedge i_clk) begin
        if (i_nrst === 1'b1 && o_done === 1'b1) done_seen++;
        if (i_nrst === 1'b1 && o_valid === 1'b1 && i_ready === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result actual=tap %0d required=no result", o_tap);
            end else begin
                exp_t e;
                e = q.pop_front();
                pops++;
                chk("sb_tap",  256'(o_tap),  256'(e.tap));
                chk("sb_ctrl", o_ctrl,       e.ctrl);
                chk("sb_data", o_data,       e.data);
                chk("sb_ones", 256'(o_ones), 256'(e.ones));
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic start_run(input logic mode, input logic [7:0] first,
                             input logic [7:0] last, input logic [7:0] step);
        i_mode  = mode;
        i_first = first;
        i_last  = last;
        i_step  = step;
        i_start = 1'b1;
        cyc(1);
        i_start = 1'b0;
    endtask

    task automatic trig();
        i_trig = 1'b0;
        cyc(3);
        i_trig = 1'b1;
        cyc(2);
    endtask

    task automatic capture(input logic [255:0] d, input logic [7:0] tap,
                           input logic [8:0] ones, input int pre);
        exp_t e;
        e.tap  = tap;
        e.ctrl = 256'd1 << tap;
        e.data = d;
        e.ones = ones;
        q.push_back(e);
        i_data = d;
        cyc(pre);
        trig();
    endtask

    initial begin
        i_nrst  = 1'b0;
        i_start = 1'b0;
        i_abort = 1'b0;
        i_mode  = 1'b0;
        i_first = '0;
        i_last  = '0;
        i_step  = '0;
        i_trig  = 1'b1;
        i_data  = '0;
        i_ready = 1'b1;
        cyc(3);
        i_nrst = 1'b1;
        cyc(2);
        chk("rst_tap",  256'(o_tap), 256'd0);
        chk("rst_ctrl", o_ctrl, 256'd1);
        chk("rst_busy", 256'(o_busy), 256'd0);
        chk("rst_valid", 256'(o_valid), 256'd0);

        // Sweep 0..3 step 1
        start_run(1'b0, 8'd0, 8'd3, 8'd1);
        capture(256'hFF,        8'd0, 9'd8,  20);
        capture(256'hA5A5,      8'd1, 9'd8,  20);
        capture(256'hFFFF_FFFF, 8'd2, 9'd32, 20);
        capture(256'h0F,        8'd3, 9'd4,  20);
        cyc(2);
        chk("sweep_done_count", 256'(done_seen), 256'd1);
        chk("sweep_idle", 256'(o_busy), 256'd0);
        chk("sweep_sb_empty", 256'(q.size()), 256'd0);

        // 250..255 step 4: wrap past last ends the run at 254
        start_run(1'b0, 8'd250, 8'd255, 8'd4);
        capture({256{1'b1}}, 8'd250, 9'd256, 20);
        capture(256'd0,      8'd254, 9'd0,   20);
        cyc(2);
        chk("top_done_count", 256'(done_seen), 256'd2);
        chk("top_tap_kept", 256'(o_tap), 256'd254);

        // Stall in SEND with a trigger edge arriving meanwhile
        start_run(1'b0, 8'd5, 8'd5, 8'd1);
        i_ready = 1'b0;
        capture(256'h0F, 8'd5, 9'd4, 20);
        chk("stall_missed_pre", 256'(o_missed), 256'd0);
        i_data = {256{1'b1}};
        for (int i = 0; i < 10; i++) begin
            chk("stall_valid", 256'(o_valid), 256'd1);
            chk("stall_data", o_data, 256'h0F);
            chk("stall_ones", 256'(o_ones), 256'd4);
            cyc(1);
        end
        trig();
        chk("stall_missed_set", 256'(o_missed), 256'd1);
        chk("stall_valid_after_trig", 256'(o_valid), 256'd1);
        i_ready = 1'b1;
        cyc(3);
        chk("stall_done_count", 256'(done_seen), 256'd3);
        chk("missed_sticky_idle", 256'(o_missed), 256'd1);

        // Abort in SEND; the started run also clears the missed flag
        i_ready = 1'b0;
        start_run(1'b0, 8'd3, 8'd3, 8'd1);
        chk("missed_cleared", 256'(o_missed), 256'd0);
        i_data = 256'h1234;
        cyc(20);
        trig();
        chk("abort_pre_valid", 256'(o_valid), 256'd1);
        i_abort = 1'b1;
        cyc(1);
        i_abort = 1'b0;
        chk("abort_valid", 256'(o_valid), 256'd0);
        chk("abort_busy", 256'(o_busy), 256'd0);
        chk("abort_tap", 256'(o_tap), 256'd3);
        cyc(2);
        chk("abort_no_done", 256'(done_seen), 256'd3);
        i_ready = 1'b1;

        // Abort and start together in IDLE
        i_abort = 1'b1;
        i_start = 1'b1;
        cyc(1);
        i_abort = 1'b0;
        i_start = 1'b0;
        chk("abort_start_busy", 256'(o_busy), 256'd0);

        // Reset pulse in the middle of SETTLE
        start_run(1'b0, 8'd9, 8'd12, 8'd1);
        cyc(8);
        chk("settle_busy", 256'(o_busy), 256'd1);
        chk("settle_tap", 256'(o_tap), 256'd9);
        i_nrst = 1'b0;
        #2;
        chk("arst_tap", 256'(o_tap), 256'd0);
        chk("arst_ctrl", o_ctrl, 256'd1);
        chk("arst_data", o_data, 256'd0);
        chk("arst_ones", 256'(o_ones), 256'd0);
        chk("arst_valid", 256'(o_valid), 256'd0);
        chk("arst_busy", 256'(o_busy), 256'd0);
        chk("arst_done", 256'(o_done), 256'd0);
        chk("arst_missed", 256'(o_missed), 256'd0);
        i_nrst = 1'b1;
        cyc(3);
        chk("arst_stays_idle", 256'(o_busy), 256'd0);
        chk("arst_no_done", 256'(done_seen), 256'd3);

        // Hold mode on tap 7: back-to-back captures with no settle gap
        start_run(1'b1, 8'd7, 8'd0, 8'd1);
        capture(256'h1,   8'd7, 9'd1, 20);
        capture(256'h3,   8'd7, 9'd2, 2);
        capture(256'h707, 8'd7, 9'd6, 2);
        chk("hold_sb_empty", 256'(q.size()), 256'd0);
        chk("hold_busy", 256'(o_busy), 256'd1);
        i_abort = 1'b1;
        cyc(1);
        i_abort = 1'b0;
        chk("hold_abort_idle", 256'(o_busy), 256'd0);

        // Trigger edges early in SETTLE are ignored
        start_run(1'b0, 8'd0, 8'd1, 8'd1);
        i_data = 256'hDEAD;
        cyc(3);
        trig();
        chk("early_trig_no_valid", 256'(o_valid), 256'd0);
        capture(256'hF0, 8'd0, 9'd4, 20);
        trig();
        chk("tapchg_trig_no_valid", 256'(o_valid), 256'd0);
        capture(256'h7, 8'd1, 9'd3, 20);
        cyc(2);
        chk("ignore_done_count", 256'(done_seen), 256'd4);

        // Step 0 behaves as step 1
        start_run(1'b0, 8'd2, 8'd4, 8'd0);
        capture(256'h11, 8'd2, 9'd2, 20);
        capture(256'h13, 8'd3, 9'd3, 20);
        capture(256'h17, 8'd4, 9'd4, 20);
        cyc(2);
        chk("step0_done_count", 256'(done_seen), 256'd5);
        chk("step0_tap", 256'(o_tap), 256'd4);

        cyc(2);
        chk("final_sb_empty", 256'(q.size()), 256'd0);
        chk("final_pops", 256'(pops), 256'd15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
